// File: rtl/rx_ds_char_if.sv
// Pad and character bundle of the data-strobe link receiver.
// master is the receiver side, slave is the pad driver / link layer.
interface rx_ds_char_if #(
    parameter int DATA_W = 8
);
    logic              d;
    logic              s;
    logic [DATA_W-1:0] rxData;
    logic              rxIsCtrl;
    logic              rxValid;
    logic              rxParityErr;
    logic              rxNull;
    logic              rxGotNull;
    logic              rxDisconnect;

    modport master (
        input  d,
        input  s,
        output rxData,
        output rxIsCtrl,
        output rxValid,
        output rxParityErr,
        output rxNull,
        output rxGotNull,
        output rxDisconnect
    );

    modport slave (
        output d,
        output s,
        input  rxData,
        input  rxIsCtrl,
        input  rxValid,
        input  rxParityErr,
        input  rxNull,
        input  rxGotNull,
        input  rxDisconnect
    );
endinterface

// File: rtl/rx_ds_char.sv
// Data-strobe receiver: synchronises d/s, recovers bits on d^s edges
// and frames odd-parity data/control characters with NULL and timeout.
module rx_ds_char #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 64
) (
    input logic          rxClk,
    input logic          rxReset,
    rx_ds_char_if.master rx
);
    localparam int IW = $clog2(DATA_W);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAR,
        ST_FLAG,
        ST_PAY
    } state_e;

    logic [SYNC_STAGES-1:0] d_sync_q, d_sync_d;
    logic [SYNC_STAGES-1:0] s_sync_q, s_sync_d;
    logic                   xs_prev_q, xs_prev_d;
    logic                   edge_q, edge_d;
    logic                   bit_q, bit_d;
    state_e                 state_q, state_d;
    logic                   ppf_q, ppf_d;
    logic                   pay_par_q, pay_par_d;
    logic                   prev_par_q, prev_par_d;
    logic                   frm_ctrl_q, frm_ctrl_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   esc_q, esc_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   is_ctrl_q, is_ctrl_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   null_q, null_d;
    logic                   got_null_q, got_null_d;
    logic                   disc_q, disc_d;

    logic          xs_now;
    logic          done;
    logic          good;
    logic [IW-1:0] last_idx;

    assign xs_now = d_sync_q[SYNC_STAGES-1] ^ s_sync_q[SYNC_STAGES-1];

    always_comb begin
        d_sync_d   = {d_sync_q[SYNC_STAGES-2:0], rx.d};
        s_sync_d   = {s_sync_q[SYNC_STAGES-2:0], rx.s};
        xs_prev_d  = xs_now;
        edge_d     = xs_now ^ xs_prev_q;
        bit_d      = d_sync_q[SYNC_STAGES-1];
        state_d    = state_q;
        ppf_d      = ppf_q;
        pay_par_d  = pay_par_q;
        prev_par_d = prev_par_q;
        frm_ctrl_d = frm_ctrl_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        tcnt_d     = tcnt_q;
        esc_d      = esc_q;
        data_d     = data_q;
        is_ctrl_d  = is_ctrl_q;
        got_null_d = got_null_q;
        disc_d     = disc_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        null_d     = 1'b0;
        done       = 1'b0;
        good       = 1'b0;
        last_idx   = frm_ctrl_q ? IW'(1) : IW'(DATA_W - 1);

        if (edge_q) begin
            tcnt_d = '0;
            disc_d = 1'b0;
            unique case (state_q)
                // prior payload counts as zeros after IDLE
                ST_IDLE: begin
                    ppf_d   = bit_q;
                    state_d = ST_FLAG;
                end
                ST_PAR: begin
                    ppf_d   = prev_par_q ^ bit_q;
                    state_d = ST_FLAG;
                end
                ST_FLAG: begin
                    ppf_d      = ppf_q ^ bit_q;
                    frm_ctrl_d = bit_q;
                    idx_d      = '0;
                    sh_d       = '0;
                    pay_par_d  = 1'b0;
                    state_d    = ST_PAY;
                end
                ST_PAY: begin
                    sh_d[idx_q] = bit_q;
                    pay_par_d   = pay_par_q ^ bit_q;
                    idx_d       = idx_q + IW'(1);
                    if (idx_q == last_idx) begin
                        done       = 1'b1;
                        good       = ppf_q ^ pay_par_d;
                        prev_par_d = pay_par_d;
                        state_d    = ST_PAR;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                disc_d     = 1'b1;
                got_null_d = 1'b0;
                esc_d      = 1'b0;
                tcnt_d     = '0;
                state_d    = ST_IDLE;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        if (done) begin
            if (good) begin
                valid_d   = 1'b1;
                data_d    = sh_d;
                is_ctrl_d = frm_ctrl_q;
                esc_d     = frm_ctrl_q && (sh_d[1:0] == 2'b11);
                if (frm_ctrl_q && sh_d[1:0] == 2'b00 && esc_q) begin
                    null_d     = 1'b1;
                    got_null_d = 1'b1;
                end
            end else begin
                perr_d     = 1'b1;
                got_null_d = 1'b0;
                esc_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            d_sync_q   <= '0;
            s_sync_q   <= '0;
            xs_prev_q  <= 1'b0;
            edge_q     <= 1'b0;
            bit_q      <= 1'b0;
            state_q    <= ST_IDLE;
            ppf_q      <= 1'b0;
            pay_par_q  <= 1'b0;
            prev_par_q <= 1'b0;
            frm_ctrl_q <= 1'b0;
            idx_q      <= '0;
            sh_q       <= '0;
            tcnt_q     <= '0;
            esc_q      <= 1'b0;
            data_q     <= '0;
            is_ctrl_q  <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            null_q     <= 1'b0;
            got_null_q <= 1'b0;
            disc_q     <= 1'b0;
        end else begin
            d_sync_q   <= d_sync_d;
            s_sync_q   <= s_sync_d;
            xs_prev_q  <= xs_prev_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            state_q    <= state_d;
            ppf_q      <= ppf_d;
            pay_par_q  <= pay_par_d;
            prev_par_q <= prev_par_d;
            frm_ctrl_q <= frm_ctrl_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            tcnt_q     <= tcnt_d;
            esc_q      <= esc_d;
            data_q     <= data_d;
            is_ctrl_q  <= is_ctrl_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            null_q     <= null_d;
            got_null_q <= got_null_d;
            disc_q     <= disc_d;
        end
    end

    assign rx.rxData       = data_q;
    assign rx.rxIsCtrl     = is_ctrl_q;
    assign rx.rxValid      = valid_q;
    assign rx.rxParityErr  = perr_q;
    assign rx.rxNull       = null_q;
    assign rx.rxGotNull    = got_null_q;
    assign rx.rxDisconnect = disc_q;
endmodule

// File: tb/tb_rx_ds_char.sv
// Directed bench for the data-strobe receiver: NULL, data, parity error,
// disconnect timeout and mid-character reset.
module tb_rx_ds_char;
    localparam int SS = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_ds_char_if #(.DATA_W(DW)) bus ();

    rx_ds_char #(
        .SYNC_STAGES(SS),
        .DATA_W     (DW),
        .TIMEOUT    (TO)
    ) dut (
        .rxClk  (clk),
        .rxReset(rst),
        .rx     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int drive_cyc = 0;
    int last_v_cyc = 0;
    int disc_cyc = -1;
    int n_perr   = 0;
    logic disc_prev = 1'b0;
    logic d_cur = 1'b0;
    logic s_cur = 1'b0;
    logic prev_par = 1'b0;
    logic [9:0] ev[$];
    logic [13:0] outs;

    assign outs = {bus.rxData, bus.rxIsCtrl, bus.rxValid,
                   bus.rxParityErr, bus.rxNull, bus.rxGotNull,
                   bus.rxDisconnect};

    always @(posedge clk) cyc <= cyc + 1;

    // event log: {rxNull, rxIsCtrl, rxData} per rxValid pulse
    always @(negedge clk) begin
        if (bus.rxValid) begin
            ev.push_back({bus.rxNull, bus.rxIsCtrl, bus.rxData});
            last_v_cyc = cyc;
        end
        if (bus.rxParityErr) n_perr++;
        if (bus.rxDisconnect && !disc_prev) disc_cyc = cyc;
        disc_prev = bus.rxDisconnect;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit hit");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        if (b != d_cur) d_cur = b;
        else s_cur = ~s_cur;
        bus.d = d_cur;
        bus.s = s_cur;
        drive_cyc = cyc;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_char(input logic f, input logic [7:0] pay,
                             input logic inv_p);
        logic p;
        int n;
        n = f ? 2 : 8;
        p = 1'b1 ^ prev_par ^ f ^ inv_p;
        send_bit(p);
        send_bit(f);
        for (int i = 0; i < n; i++) send_bit(pay[i]);
        prev_par = 1'b0;
        for (int i = 0; i < n; i++) prev_par = prev_par ^ pay[i];
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        bus.d = 1'b0;
        bus.s = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            bus.d = ~bus.d;
            bus.s = (i == 0);
            @(negedge clk);
            n_checks++;
            if (outs !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_hold%0d: got %h want 0", i, outs);
            end
        end
        @(posedge clk);
        #1;
        bus.d = 1'b0;
        bus.s = 1'b0;
        d_cur = 1'b0;
        s_cur = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        n_checks++;
        if (outs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h want 0", outs);
        end
        prev_par = 1'b0;
    endtask

    task automatic test_null();
        ev.delete();
        send_char(1'b1, 8'h03, 1'b0);
        send_char(1'b1, 8'h00, 1'b0);
        settle();
        n_checks++;
        if (ev.size() !== 2) begin
            n_fail++;
            $display("FAIL null_count: got %0d want 2", ev.size());
        end else begin
            n_checks++;
            if (ev[0] !== 10'h103) begin
                n_fail++;
                $display("FAIL null_esc: got %h want 103", ev[0]);
            end
            n_checks++;
            if (ev[1] !== 10'h300) begin
                n_fail++;
                $display("FAIL null_fct: got %h want 300", ev[1]);
            end
        end
        n_checks++;
        if (bus.rxGotNull !== 1'b1 || n_perr !== 0) begin
            n_fail++;
            $display("FAIL null_got: got %b/%0d want 1/0",
                     bus.rxGotNull, n_perr);
        end
    endtask

    task automatic test_data();
        ev.delete();
        send_char(1'b0, 8'hA5, 1'b0);
        settle();
        n_checks++;
        if (ev.size() !== 1 || ev[0] !== 10'h0A5) begin
            n_fail++;
            $display("FAIL data_a5: got n=%0d %h want 1 0a5",
                     ev.size(), ev.size() ? ev[0] : 10'h0);
        end
        n_checks++;
        if (last_v_cyc - drive_cyc !== SS + 2) begin
            n_fail++;
            $display("FAIL data_latency: got %0d want %0d",
                     last_v_cyc - drive_cyc, SS + 2);
        end
        n_checks++;
        if (n_perr !== 0 || bus.rxGotNull !== 1'b1) begin
            n_fail++;
            $display("FAIL data_flags: got perr=%0d got_null=%b want 0 1",
                     n_perr, bus.rxGotNull);
        end
    endtask

    task automatic test_parity();
        ev.delete();
        send_char(1'b0, 8'h3C, 1'b1);
        settle();
        n_checks++;
        if (ev.size() !== 0 || n_perr !== 1) begin
            n_fail++;
            $display("FAIL perr_pulse: got valid=%0d perr=%0d want 0 1",
                     ev.size(), n_perr);
        end
        n_checks++;
        if (bus.rxData !== 8'hA5 || bus.rxGotNull !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_hold: got %h/%b want a5/0",
                     bus.rxData, bus.rxGotNull);
        end
        send_char(1'b1, 8'h00, 1'b0);
        settle();
        n_checks++;
        if (ev.size() !== 1 || ev[0] !== 10'h100 || n_perr !== 1) begin
            n_fail++;
            $display("FAIL perr_next_fct: got n=%0d %h perr=%0d want 1 100 1",
                     ev.size(), ev.size() ? ev[0] : 10'h0, n_perr);
        end
    endtask

    task automatic test_timeout();
        ev.delete();
        send_char(1'b1, 8'h03, 1'b0);
        send_char(1'b1, 8'h00, 1'b0);
        settle();
        n_checks++;
        if (bus.rxGotNull !== 1'b1 || bus.rxDisconnect !== 1'b0) begin
            n_fail++;
            $display("FAIL to_pre: got %b%b want 10",
                     bus.rxGotNull, bus.rxDisconnect);
        end
        disc_cyc = -1;
        for (int i = 0; i < 4 * TO && !bus.rxDisconnect; i++)
            @(negedge clk);
        #2;
        n_checks++;
        if (disc_cyc - last_v_cyc !== TO) begin
            n_fail++;
            $display("FAIL to_delay: got %0d want %0d",
                     disc_cyc - last_v_cyc, TO);
        end
        n_checks++;
        if (bus.rxDisconnect !== 1'b1 || bus.rxGotNull !== 1'b0) begin
            n_fail++;
            $display("FAIL to_flags: got %b%b want 10",
                     bus.rxDisconnect, bus.rxGotNull);
        end
        prev_par = 1'b0;
        ev.delete();
        send_char(1'b1, 8'h03, 1'b0);
        settle();
        n_checks++;
        if (bus.rxDisconnect !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: got %b want 0", bus.rxDisconnect);
        end
        send_char(1'b1, 8'h00, 1'b0);
        settle();
        n_checks++;
        if (ev.size() !== 2 || ev[1] !== 10'h300 || bus.rxGotNull !== 1'b1) begin
            n_fail++;
            $display("FAIL to_renull: got n=%0d got_null=%b want 2 1",
                     ev.size(), bus.rxGotNull);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] part;
        part = 4'b1101;
        ev.delete();
        send_bit(1'b1 ^ prev_par);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(part[i]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.d = 1'b0;
        bus.s = 1'b0;
        d_cur = 1'b0;
        s_cur = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (outs !== 14'd0) begin
            n_fail++;
            $display("FAIL rstmid_outs: got %h want 0", outs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_par = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (ev.size() !== 0 || outs !== 14'd0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got n=%0d %h want 0 0",
                     ev.size(), outs);
        end
        send_char(1'b1, 8'h03, 1'b0);
        send_char(1'b1, 8'h00, 1'b0);
        settle();
        n_checks++;
        if (ev.size() !== 2 || ev[1] !== 10'h300 || bus.rxGotNull !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_null: got n=%0d got_null=%b want 2 1",
                     ev.size(), bus.rxGotNull);
        end
        n_checks++;
        if (n_perr !== 1) begin
            n_fail++;
            $display("FAIL rstmid_perr: got %0d want 1", n_perr);
        end
    endtask

    initial begin
        bus.d = 1'b0;
        bus.s = 1'b0;
        test_reset();
        test_null();
        test_data();
        test_parity();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
